// File: rtl/rapid_pkg.sv
// Shared decode types for the rapid core: execute control bundle, decode output
// record and RV32I/RV64I major-opcode constants.
package rapid_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] lui_family     = 7'b0110111;
  localparam logic [6:0] auipc_family   = 7'b0010111;
  localparam logic [6:0] jal_family     = 7'b1101111;
  localparam logic [6:0] jalr_family    = 7'b1100111;
  localparam logic [6:0] branch_family  = 7'b1100011;
  localparam logic [6:0] load_family    = 7'b0000011;
  localparam logic [6:0] store_family   = 7'b0100011;
  localparam logic [6:0] alu_imm_family = 7'b0010011;
  localparam logic [6:0] alu_reg_family = 7'b0110011;
  localparam logic [6:0] fence_family   = 7'b0001111;

  localparam logic [6:0] funct7_base = 7'b0000000;
  localparam logic [6:0] funct7_alt  = 7'b0100000;
  localparam logic [6:0] funct7_m    = 7'b0000001;

  typedef struct packed {
    logic [31:0] debug_instruction;
    logic [2:0]  fcs_opcode;
    logic        iop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_out;
    logic        rs2_out;
    logic        alu_reg;
    logic        alu_imm;
    logic        load;
    logic        store;
    logic        cond_branch;
    logic        uncond_branch;
    logic        load_upper_imm;
    logic        muldiv;
  } control_ex_s;

  // imm and pc are held at the widest XLEN; narrower stages use the low bits.
  typedef struct packed {
    control_ex_s          ctrl;
    logic [XLEN_MAX-1:0]  imm;
    logic [XLEN_MAX-1:0]  pc;
    logic                 illegal;
  } decode_out_s;

  function automatic control_ex_s control_ex_s_default();
    control_ex_s c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational RV32I/RV64I decoder: instruction word and PC to a decode record,
// including immediate generation and illegal-instruction detection.
module decode_core
  import rapid_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  output decode_out_s     dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  shift_hi;
  logic        shift_arith, shift_ok, load_ok, store_ok;
  control_ex_s base, ctrl;
  logic        illegal;
  logic [63:0] imm;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {{32{instruction[31]}}, instruction[31:12], 12'h000};
  assign imm_j = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // RV64 widens shamt to 6 bits, so only [31:26] remain as the shift-type field.
  assign shift_hi    = (XLEN == 64) ? {1'b0, instruction[31:26]} : instruction[31:25];
  assign shift_arith = (XLEN == 64) ? (shift_hi == 7'b0010000) : (shift_hi == 7'b0100000);
  assign shift_ok    = (shift_hi == 7'b0000000) || (shift_arith && (funct3 == 3'b101));
  assign load_ok     = (funct3 == 3'd7) ? 1'b0 :
                       ((funct3 == 3'd3) || (funct3 == 3'd6)) ? (XLEN == 64) : 1'b1;
  assign store_ok    = (funct3 <= 3'd2) || ((funct3 == 3'd3) && (XLEN == 64));

  always_comb begin
    base                   = control_ex_s_default();
    base.debug_instruction = instruction;
    base.fcs_opcode        = funct3;
    ctrl                   = base;
    illegal                = 1'b0;
    imm                    = 64'd0;
    if (instruction[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        lui_family, auipc_family: begin
          ctrl.load_upper_imm = 1'b1;
          ctrl.iop            = (opcode == auipc_family);
          ctrl.rd             = instruction[11:7];
          imm                 = imm_u;
        end
        jal_family: begin
          ctrl.uncond_branch = 1'b1;
          ctrl.rd            = instruction[11:7];
          imm                = imm_j;
        end
        jalr_family: begin
          ctrl.uncond_branch = 1'b1;
          ctrl.iop           = 1'b1;
          ctrl.rd            = instruction[11:7];
          ctrl.rs1           = instruction[19:15];
          ctrl.rs1_out       = 1'b1;
          imm                = imm_i;
          illegal            = (funct3 != 3'b000);
        end
        branch_family: begin
          ctrl.cond_branch = 1'b1;
          ctrl.rs1         = instruction[19:15];
          ctrl.rs2         = instruction[24:20];
          ctrl.rs1_out     = 1'b1;
          ctrl.rs2_out     = 1'b1;
          imm              = imm_b;
          illegal          = (funct3 == 3'd2) || (funct3 == 3'd3);
        end
        load_family: begin
          ctrl.load    = 1'b1;
          ctrl.rd      = instruction[11:7];
          ctrl.rs1     = instruction[19:15];
          ctrl.rs1_out = 1'b1;
          imm          = imm_i;
          illegal      = !load_ok;
        end
        store_family: begin
          ctrl.store   = 1'b1;
          ctrl.rs1     = instruction[19:15];
          ctrl.rs2     = instruction[24:20];
          ctrl.rs1_out = 1'b1;
          ctrl.rs2_out = 1'b1;
          imm          = imm_s;
          illegal      = !store_ok;
        end
        alu_imm_family: begin
          ctrl.alu_imm = 1'b1;
          ctrl.rd      = instruction[11:7];
          ctrl.rs1     = instruction[19:15];
          ctrl.rs1_out = 1'b1;
          imm          = imm_i;
          if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
            ctrl.iop = shift_arith && (funct3 == 3'b101);
            illegal  = !shift_ok;
          end else begin
            ctrl.iop = 1'b0;
          end
        end
        alu_reg_family: begin
          ctrl.alu_reg = 1'b1;
          ctrl.rd      = instruction[11:7];
          ctrl.rs1     = instruction[19:15];
          ctrl.rs2     = instruction[24:20];
          ctrl.rs1_out = 1'b1;
          ctrl.rs2_out = 1'b1;
          if (funct7 == funct7_m) begin
            ctrl.muldiv = EN_M;
            illegal     = !EN_M;
          end else if ((funct7 == funct7_base) ||
                       ((funct7 == funct7_alt) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
            ctrl.iop = funct7[5];
          end else begin
            illegal = 1'b1;
          end
        end
        fence_family: begin
          illegal = 1'b0;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

  // Illegal words keep only the debug word and funct3; every block flag stays clear.
  assign dec.ctrl    = illegal ? base : ctrl;
  assign dec.imm     = illegal ? 64'd0 : imm;
  assign dec.pc      = 64'(pc);
  assign dec.illegal = illegal;

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes each accepted fetch word and queues the result
// in a DEPTH-entry circular buffer that feeds execute through valid/ready.
module decode_stage
  import rapid_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [31:0]       i_instruction,
  input  logic [XLEN-1:0]   i_pc,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output control_ex_s       o_control_signal,
  output logic [XLEN-1:0]   o_imm,
  output logic [XLEN-1:0]   o_pc,
  output logic              o_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  decode_out_s          dec;
  decode_out_s          entries [DEPTH];
  logic [PW-1:0]        head, tail;
  logic [CW-1:0]        count;
  logic                 push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  decode_core #(.XLEN(XLEN), .EN_M(EN_M)) u_core (
    .instruction (i_instruction),
    .pc          (i_pc),
    .dec         (dec)
  );

  // Ready comes from the registered count only, so a full buffer never passes through.
  assign o_ready = (count != CW'(DEPTH));
  assign o_valid = (count != CW'(0));
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = o_valid && i_ready;

  // Buffer storage, pointers and occupancy; flush overrides any push or pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '{ctrl: control_ex_s_default(), imm: '0, pc: '0, illegal: 1'b0};
      end
    end else if (i_flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) begin
        entries[tail] <= dec;
        tail          <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign o_control_signal = entries[head].ctrl;
  assign o_imm            = entries[head].imm[XLEN-1:0];
  assign o_pc             = entries[head].pc[XLEN-1:0];
  assign o_illegal        = entries[head].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table run through two
// instances (M extension off/on) plus backpressure, flush and async-reset sequences.
module tb_decode_stage;
  import rapid_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] pc    = 32'd0;

  logic        m0_ready, m0_valid, m0_illegal;
  logic        m1_ready, m1_valid, m1_illegal;
  control_ex_s m0_ctrl, m1_ctrl;
  logic [31:0] m0_imm, m0_pc, m1_imm, m1_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic [26:0] sig0;
    logic [26:0] sig1;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs [17];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(2), .EN_M(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid),
    .i_instruction(instr), .i_pc(pc), .o_ready(m0_ready), .o_valid(m0_valid),
    .i_ready(ready), .o_control_signal(m0_ctrl), .o_imm(m0_imm), .o_pc(m0_pc),
    .o_illegal(m0_illegal)
  );

  decode_stage #(.XLEN(32), .DEPTH(2), .EN_M(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid),
    .i_instruction(instr), .i_pc(pc), .o_ready(m1_ready), .o_valid(m1_valid),
    .i_ready(ready), .o_control_signal(m1_ctrl), .o_imm(m1_imm), .o_pc(m1_pc),
    .o_illegal(m1_illegal)
  );

  // flags order: alu_reg alu_imm load store branch uncond_branch load_upper_imm muldiv
  function automatic logic [26:0] mk(input logic ill, input logic [7:0] flags, input logic iop,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic r1o, input logic r2o);
    return {ill, flags, iop, r1o, r2o, rd, rs1, rs2};
  endfunction

  function automatic logic [26:0] sig_of(input control_ex_s c, input logic ill);
    return {ill, c.alu_reg, c.alu_imm, c.load, c.store, c.cond_branch, c.uncond_branch,
            c.load_upper_imm, c.muldiv, c.iop, c.rs1_out, c.rs2_out, c.rd, c.rs1, c.rs2};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [26:0] ill_sig;
    ill_sig = mk(1'b1, 8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    vecs[0]  = '{32'hFFF00093, mk(1'b0, 8'b0100_0000, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0),
                 mk(1'b0, 8'b0100_0000, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0), 32'hFFFFFFFF};
    vecs[1]  = '{32'h000010B7, mk(1'b0, 8'b0000_0010, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0),
                 mk(1'b0, 8'b0000_0010, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0), 32'h00001000};
    vecs[2]  = '{32'h00001517, mk(1'b0, 8'b0000_0010, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0),
                 mk(1'b0, 8'b0000_0010, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0), 32'h00001000};
    vecs[3]  = '{32'h00000000, ill_sig, ill_sig, 32'h0};
    vecs[4]  = '{32'h02208033, ill_sig,
                 mk(1'b0, 8'b1000_0001, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1), 32'h0};
    vecs[5]  = '{32'h402081B3, mk(1'b0, 8'b1000_0000, 1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1),
                 mk(1'b0, 8'b1000_0000, 1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1), 32'h0};
    vecs[6]  = '{32'h004280E7, mk(1'b0, 8'b0000_0100, 1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0),
                 mk(1'b0, 8'b0000_0100, 1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0), 32'h4};
    vecs[7]  = '{32'hFFDFF06F, mk(1'b0, 8'b0000_0100, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0),
                 mk(1'b0, 8'b0000_0100, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), 32'hFFFFFFFC};
    vecs[8]  = '{32'hFE208CE3, mk(1'b0, 8'b0000_1000, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1),
                 mk(1'b0, 8'b0000_1000, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1), 32'hFFFFFFF8};
    vecs[9]  = '{32'h0020A063, ill_sig, ill_sig, 32'h0};
    vecs[10] = '{32'h0020A623, mk(1'b0, 8'b0001_0000, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1),
                 mk(1'b0, 8'b0001_0000, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1), 32'd12};
    vecs[11] = '{32'hFF012283, mk(1'b0, 8'b0010_0000, 1'b0, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0),
                 mk(1'b0, 8'b0010_0000, 1'b0, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0), 32'hFFFFFFF0};
    vecs[12] = '{32'h00013283, ill_sig, ill_sig, 32'h0};
    vecs[13] = '{32'h4030D093, mk(1'b0, 8'b0100_0000, 1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0),
                 mk(1'b0, 8'b0100_0000, 1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0), 32'h00000403};
    vecs[14] = '{32'h40309093, ill_sig, ill_sig, 32'h0};
    vecs[15] = '{32'h0FF0000F, mk(1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0),
                 mk(1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), 32'h0};
    vecs[16] = '{32'h00000001, ill_sig, ill_sig, 32'h0};

    // Reset state, sampled while reset is still asserted.
    #2;
    chk("rst_valid", 64'(m0_valid), 64'd0);
    chk("rst_ready", 64'(m0_ready), 64'd1);
    chk("rst_illegal", 64'(m0_illegal), 64'd0);
    chk("rst_imm", 64'(m0_imm), 64'd0);
    chk("rst_pc", 64'(m0_pc), 64'd0);
    chk("rst_ctrl", 64'(sig_of(m0_ctrl, 1'b0)), 64'd0);
    chk("rst_debug", 64'(m0_ctrl.debug_instruction), 64'd0);
    step();
    step();
    rst = 1'b0;

    // Decode table, streamed at full rate with execute always ready.
    ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      instr = vecs[i].word;
      pc    = 32'h1000 + 32'(4 * i);
      valid = 1'b1;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(m0_valid), 64'd1);
      chk($sformatf("vec%0d_sig_m0", i), 64'(sig_of(m0_ctrl, m0_illegal)), 64'(vecs[i].sig0));
      chk($sformatf("vec%0d_sig_m1", i), 64'(sig_of(m1_ctrl, m1_illegal)), 64'(vecs[i].sig1));
      chk($sformatf("vec%0d_imm", i), 64'(m0_imm), 64'(vecs[i].imm));
      chk($sformatf("vec%0d_pc", i), 64'(m0_pc), 64'(32'h1000 + 32'(4 * i)));
      chk($sformatf("vec%0d_debug", i), 64'(m0_ctrl.debug_instruction), 64'(vecs[i].word));
    end
    valid = 1'b0;
    step();
    chk("drain_empty", 64'(m0_valid), 64'd0);

    // Backpressure: three pushes into a two-entry buffer, then drain in order.
    ready = 1'b0;
    valid = 1'b1;
    instr = 32'h00100093;
    step();
    chk("bp_ready_after1", 64'(m0_ready), 64'd1);
    instr = 32'h00200093;
    step();
    chk("bp_ready_after2", 64'(m0_ready), 64'd0);
    instr = 32'h00300093;
    step();
    chk("bp_ready_held", 64'(m0_ready), 64'd0);
    chk("bp_head_stable", 64'(m0_imm), 64'd1);
    ready = 1'b1;
    step();
    chk("bp_drain1_valid", 64'(m0_valid), 64'd1);
    chk("bp_drain1_imm", 64'(m0_imm), 64'd2);
    step();
    valid = 1'b0;
    chk("bp_drain2_imm", 64'(m0_imm), 64'd3);
    step();
    chk("bp_drain_empty", 64'(m0_valid), 64'd0);

    // Flush with two buffered entries and a concurrent input.
    ready = 1'b0;
    valid = 1'b1;
    instr = 32'h00100093;
    step();
    instr = 32'h00200093;
    step();
    chk("fl_full", 64'(m0_ready), 64'd0);
    flush = 1'b1;
    instr = 32'h00700093;
    step();
    flush = 1'b0;
    valid = 1'b0;
    chk("fl_valid", 64'(m0_valid), 64'd0);
    chk("fl_ready", 64'(m0_ready), 64'd1);
    step();
    chk("fl_no_ghost", 64'(m0_valid), 64'd0);
    valid = 1'b1;
    instr = 32'h00500093;
    step();
    valid = 1'b0;
    chk("fl_resume_imm", 64'(m0_imm), 64'd5);
    chk("fl_resume_valid", 64'(m0_valid), 64'd1);

    // Asynchronous reset mid-cycle with one buffered entry.
    ready = 1'b1;
    step();
    ready = 1'b0;
    valid = 1'b1;
    instr = 32'h00800093;
    pc    = 32'h00002000;
    step();
    valid = 1'b0;
    chk("ar_before", 64'(m0_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(m0_valid), 64'd0);
    chk("ar_ready", 64'(m0_ready), 64'd1);
    chk("ar_pc", 64'(m0_pc), 64'd0);
    #2;
    rst   = 1'b0;
    valid = 1'b1;
    instr = 32'h00900093;
    pc    = 32'h00003000;
    step();
    valid = 1'b0;
    chk("ar_resume_valid", 64'(m0_valid), 64'd1);
    chk("ar_resume_imm", 64'(m0_imm), 64'd9);
    chk("ar_resume_pc", 64'(m0_pc), 64'h3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised RV32I/RV64I instruction decode stage with valid/ready handshakes on both sides and a DEPTH-entry output buffer. Sits between fetch and execute. Each accepted instruction is turned into a registered decode bundle: `control_ex_s`, sign-extended immediate, PC and illegal flag. The stage supports flush for branch redirects, AUIPC/LUI distinction, JALR rs1 read-out, optional M-extension decode and illegal-instruction detection.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; immediates sign-extend to XLEN.
- `DEPTH`, 2: output buffer entries, ≥1.
- `EN_M`, 0: 1 decodes MUL/DIV group; 0 flags it illegal.
- `i_clk`  in  1  single clock; all state on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_flush`  in  1  discard all buffered entries and the current input.
- `i_valid`  in  1  fetch presents an instruction.
- `i_instruction`  in  32  instruction word.
- `i_pc`  in  XLEN  PC of instruction.
- `o_ready`  out  1  stage can accept; equals !full.
- `o_valid`  out  1  head entry valid.
- `i_ready`  in  1  execute consumes head.
- `o_control_signal`  out  control_ex_s  head decode bundle.
- `o_imm`  out  XLEN signed  head immediate.
- `o_pc`  out  XLEN  head PC.
- `o_illegal`  out  1  head instruction is illegal.

## Operation
- The push condition is `i_valid && o_ready && !i_flush`. The pop condition is `o_valid && i_ready`.
- Decode: start from `control_ex_s_default()` with `debug_instruction` set to the word and `fcs_opcode` = [14:12].
  - LUI 0110111: `load_upper_imm`=1, iop=0.
  - AUIPC 0010111: `load_upper_imm`=1, iop=1.
  - JAL: `uncond_branch`=1, iop=0, rd.
  - JALR: `uncond_branch`=1, iop=1, rd, rs1 with `rs1_out`=1.
  - Branch, load, store and ALU groups are decoded as in the current RV32I field map.
  - FENCE 0001111: legal, no block flag set.
- Immediates: I/S/B/U/J formats are sign-extended from bit 31 to XLEN. U-format is [31:12]<<12, then sign-extended.
- The M group is reg opcode with funct7=0000001. With EN_M=1 it sets `alu_reg`=1 and `muldiv`=1, iop=0. With EN_M=0 it is illegal.
- Illegal when any of the following holds:
  - [1:0]≠11 or unknown opcode.
  - Load funct3 ∈{3,6,7}; with XLEN=64, funct3 3 (LD) and 6 (LWU) are legal.
  - Store funct3>2 (3 legal at XLEN=64).
  - Branch funct3 ∈{2,3}.
  - JALR funct3≠0.
  - Reg funct7 ∉{0000000,0100000,M}, or 0100000 with funct3 ∉{000,101}.
  - Shift-imm upper bits ≠0/010000 (the shamt width is 5 bits at XLEN=32, 6 bits at 64).
- Illegal entries are still enqueued. They carry o_illegal=1, all block flags 0 and rs*_out=0, and the debug word is kept.
- Buffer: a circular FIFO with head/tail pointers mod DEPTH and a count of 0..DEPTH. The outputs are driven directly from the head entry register.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- When full, o_ready=0. There is no same-cycle pass-through, even if a pop occurs.
- Flush: at the next edge count, head and tail are set to 0 and o_valid=0. A push in the same cycle is dropped. Flush has priority over push/pop.

## Timing
- Reset (asynchronous, immediate) sets:
  - count=0, pointers=0.
  - o_valid=0, o_ready=1, o_illegal=0.
  - o_control_signal=default, o_imm=0, o_pc=0.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N if the buffer was empty. Throughput is 1 per cycle.
- o_ready depends only on registered count; there is no combinational path from i_ready.
- o_valid and the head payload are held stable while o_valid && !i_ready.
- Reset mid-operation: outputs clear without waiting for a clock edge. Accepts resume on the first edge after i_rst deasserts.

## Structure
- Additions to `rapid_pkg`:
  - opcode constants, including `auipc_family`=0010111 and `fence_family`=0001111;
  - a `muldiv` bit in `control_ex_s`;
  - a `decode_out_s` struct {ctrl, imm, pc, illegal}.
- Sub-module `decode_core`: purely combinational, parametrised XLEN/EN_M. It maps instruction and PC to `decode_out_s`.
- `decode_stage` instantiates `decode_core` and holds an array of DEPTH `decode_out_s` entries plus the control logic.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), pushed at edge N → after N: o_valid=1, alu_imm=1, rd=1, rs1=0, rs1_out=1, o_imm=0xFFFFFFFF.
- LUI 0x000010B7 then AUIPC 0x00001517 → both load_upper_imm=1, o_imm=0x00001000. iop is 0 then 1; rd is 1 then 10.
- DEPTH=2, i_ready=0, three back-to-back pushes → o_ready drops after 2 accepts and the third is held by fetch. Raise i_ready → all three drain in order, one per cycle.
- Buffer holding 2 entries, i_flush=1 together with i_valid=1 → next cycle o_valid=0, o_ready=1. The flushed input never appears.
- Word 0x00000000 → o_illegal=1, all flags 0. MUL 0x02208033 → illegal with EN_M=0; with EN_M=1: muldiv=1, alu_reg=1, rs1=1, rs2=2.
- One buffered entry, i_rst asserted mid-cycle → o_valid=0 before the next edge. After release, a new push is accepted normally.
